// File: rtl/clock_sequencer_pkg.sv
// Shared types and the speed-to-divider-limit mapping for the TD4 clock sequencer.
package clock_sequencer_pkg;

  typedef enum logic [1:0] {
    PAUSE   = 2'd0,
    RUN     = 2'd1,
    STOPPED = 2'd2
  } seq_state_t;

  typedef logic [1:0] speed_t;

  localparam speed_t SPEED_1HZ   = 2'd0;
  localparam speed_t SPEED_10HZ  = 2'd1;
  localparam speed_t SPEED_100HZ = 2'd2;
  localparam speed_t SPEED_FULL  = 2'd3;

  // Terminal count of the divider; the tick period is limit+1 cycles.
  function automatic int unsigned limit_of(input speed_t speed, input int unsigned clk_hz);
    case (speed)
      SPEED_1HZ:   return clk_hz - 1;
      SPEED_10HZ:  return clk_hz / 10 - 1;
      SPEED_100HZ: return clk_hz / 100 - 1;
      default:     return 0;
    endcase
  endfunction

endpackage

// File: rtl/clock_sequencer_button_debouncer.sv
// Two-flop synchronizer, stable-count debounce and registered rising-edge pulse
// for a raw mechanical push button.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock_in,
  input  logic reset,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level_d;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      level_out  <= 1'b0;
      level_d    <= 1'b0;
      rise_pulse <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_p0 <= raw_in;
      sync_p1 <= sync_p0;
      // Output follows only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (sync_p1 != level_out) begin
        if (stable_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level_out  <= sync_p1;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end else begin
        stable_cnt <= '0;
      end
      level_d    <= level_out;
      rise_pulse <= level_out & ~level_d;
    end
  end

endmodule

// File: rtl/clock_sequencer.sv
// Generates the TD4 cpu_tick clock-enable: free-run at a selectable rate,
// single-step from a debounced button, or stop on a core halt request.
module clock_sequencer
  import clock_sequencer_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       run_sw,
  input  logic       step_btn,
  input  logic [1:0] speed_sel,
  input  logic       halt_req,
  output logic       cpu_tick,
  output logic       tick_led,
  output logic [1:0] seq_state
);

  seq_state_t       state;
  seq_state_t       state_next;
  logic             run_p0;
  logic             run_p1;
  speed_t           speed_p0;
  speed_t           speed_p1;
  logic             step_pulse;
  logic             step_level_unused;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] limit;
  logic             tick_next;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_debouncer (
    .clock_in  (clock_in),
    .reset     (reset),
    .raw_in    (step_btn),
    .level_out (step_level_unused),
    .rise_pulse(step_pulse)
  );

  assign limit     = CNT_W'(limit_of(speed_p1, CLK_HZ));
  assign seq_state = state;

  // Stage p0/p1: switch synchronizers
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      run_p0   <= 1'b0;
      run_p1   <= 1'b0;
      speed_p0 <= '0;
      speed_p1 <= '0;
    end else begin
      run_p0   <= run_sw;
      run_p1   <= run_p0;
      speed_p0 <= speed_sel;
      speed_p1 <= speed_p0;
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) state <= PAUSE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      PAUSE:   if (run_p1 && !halt_req) state_next = RUN;
      RUN: begin
        if (halt_req)     state_next = STOPPED;
        else if (!run_p1) state_next = PAUSE;
      end
      STOPPED: if (!run_p1) state_next = PAUSE;
      default: state_next = PAUSE;
    endcase
  end

  // Counter only advances while staying in RUN; every exit leaves it at zero.
  always_comb begin
    tick_next = 1'b0;
    cnt_next  = '0;
    case (state)
      PAUSE: tick_next = step_pulse & ~halt_req;
      RUN: begin
        if (!halt_req && run_p1) begin
          if (cnt >= limit) tick_next = 1'b1;
          else              cnt_next  = cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Stage p2: registered tick, LED and divider count
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      cpu_tick <= 1'b0;
      tick_led <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      cpu_tick <= tick_next;
      tick_led <= tick_led ^ tick_next;
    end
  end

endmodule

// File: tb/tb_clock_sequencer.sv
// Bench for clock_sequencer: directed scenarios plus randomized inputs, all
// checked cycle by cycle against a behavioural model of the sequencing rules.
module tb_clock_sequencer;

  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned DEB    = 4;

  logic       clock_in = 1'b0;
  logic       reset    = 1'b1;
  logic       run_sw   = 1'b0;
  logic       step_btn = 1'b0;
  logic [1:0] speed_sel = 2'd2;
  logic       halt_req = 1'b0;
  logic       cpu_tick;
  logic       tick_led;
  logic [1:0] seq_state;

  clock_sequencer #(
    .CLK_HZ(CLK_HZ),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(32)
  ) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .run_sw   (run_sw),
    .step_btn (step_btn),
    .speed_sel(speed_sel),
    .halt_req (halt_req),
    .cpu_tick (cpu_tick),
    .tick_led (tick_led),
    .seq_state(seq_state)
  );

  always #5 clock_in = ~clock_in;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;

  // Reference model state: plain integers, 0=pause 1=run 2=stopped.
  int lim_tab [4];
  int m_run_q [2];
  int m_spd_q [2];
  int m_stp_q [2];
  int m_deb, m_deb_d, m_rise, m_stab;
  int m_state, m_cnt, m_tick, m_led;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run_q[i] = 0; m_spd_q[i] = 0; m_stp_q[i] = 0;
    end
    m_deb = 0; m_deb_d = 0; m_rise = 0; m_stab = 0;
    m_state = 0; m_cnt = 0; m_tick = 0; m_led = 0;
  endtask

  task automatic model_update();
    int run_s, spd_s, stp_s, pulse, lim, halt, nstate, ntick;
    if (reset) begin
      model_reset();
      return;
    end
    run_s = m_run_q[1];
    spd_s = m_spd_q[1];
    stp_s = m_stp_q[1];
    pulse = m_rise;
    halt  = int'(halt_req);
    lim   = lim_tab[spd_s];
    ntick  = 0;
    nstate = m_state;
    if (m_state == 0) begin
      m_cnt = 0;
      if (pulse == 1 && halt == 0) ntick = 1;
      if (run_s == 1 && halt == 0) nstate = 1;
    end else if (m_state == 1) begin
      if (halt == 1) begin
        nstate = 2; m_cnt = 0;
      end else if (run_s == 0) begin
        nstate = 0; m_cnt = 0;
      end else if (m_cnt >= lim) begin
        ntick = 1; m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else begin
      if (run_s == 0) nstate = 0;
    end
    m_state = nstate;
    m_tick  = ntick;
    m_led   = m_led ^ ntick;
    m_rise  = (m_deb == 1 && m_deb_d == 0) ? 1 : 0;
    m_deb_d = m_deb;
    if (stp_s != m_deb) begin
      m_stab = m_stab + 1;
      if (m_stab == DEB) begin
        m_deb = stp_s; m_stab = 0;
      end
    end else begin
      m_stab = 0;
    end
    m_run_q[1] = m_run_q[0]; m_run_q[0] = int'(run_sw);
    m_spd_q[1] = m_spd_q[0]; m_spd_q[0] = int'(speed_sel);
    m_stp_q[1] = m_stp_q[0]; m_stp_q[0] = int'(step_btn);
  endtask

  task automatic step_cycle();
    @(posedge clock_in);
    model_update();
    #1;
    check("cpu_tick", int'(cpu_tick), m_tick);
    check("tick_led", int'(tick_led), m_led);
    check("seq_state", int'(seq_state), m_state);
    if (cpu_tick) tick_cnt++;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  initial begin
    int n;
    lim_tab[0] = CLK_HZ - 1;
    lim_tab[1] = CLK_HZ / 10 - 1;
    lim_tab[2] = CLK_HZ / 100 - 1;
    lim_tab[3] = 0;
    model_reset();

    // Reset, then idle in pause with no button activity
    run_cycles(3);
    reset = 1'b0;
    tick_cnt = 0;
    run_cycles(200);
    check("idle_ticks", tick_cnt, 0);
    check("idle_state", int'(seq_state), 0);
    check("idle_led", int'(tick_led), 0);

    // Bouncy press then a clean press, one tick each
    tick_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step_btn = ((i % 2) == 0);
      step_cycle();
    end
    step_btn = 1'b1; run_cycles(10);
    step_btn = 1'b0; run_cycles(10);
    check("bounce_ticks", tick_cnt, 1);
    check("bounce_led", int'(tick_led), 1);
    step_btn = 1'b1; run_cycles(10);
    step_btn = 1'b0; run_cycles(10);
    check("press2_ticks", tick_cnt, 2);
    check("press2_led", int'(tick_led), 0);

    // Free-run at each rate
    run_sw = 1'b1; speed_sel = 2'd2;
    run_cycles(3);
    check("run_entry_state", int'(seq_state), 1);
    run_cycles(5);
    tick_cnt = 0; run_cycles(100);
    check("speed2_ticks", tick_cnt, 10);
    speed_sel = 2'd3; run_cycles(4);
    tick_cnt = 0; run_cycles(20);
    check("speed3_ticks", tick_cnt, 20);
    speed_sel = 2'd1; run_cycles(4);
    tick_cnt = 0; run_cycles(300);
    check("speed1_ticks", tick_cnt, 3);

    // Slow count interrupted by a faster rate: tick as soon as the change lands
    speed_sel = 2'd0;
    n = 0;
    while (m_cnt != 500 && n < 1200) begin step_cycle(); n++; end
    check("reach_cnt500", int'(m_cnt == 500), 1);
    speed_sel = 2'd2;
    n = 0;
    do begin step_cycle(); n++; end while (!cpu_tick && n < 10);
    check("speedup_latency", n, 3);
    tick_cnt = 0; run_cycles(50);
    check("speedup_period", tick_cnt, 5);

    // Halt exactly at terminal count, then leave via the run switch
    n = 0;
    while (m_cnt != lim_tab[2] && n < 20) begin step_cycle(); n++; end
    check("reach_terminal", m_cnt, lim_tab[2]);
    halt_req = 1'b1; step_cycle();
    check("halt_no_tick", int'(cpu_tick), 0);
    check("halt_state", int'(seq_state), 2);
    halt_req = 1'b0;
    tick_cnt = 0; run_cycles(30);
    check("stopped_ticks", tick_cnt, 0);
    check("stopped_state", int'(seq_state), 2);
    run_sw = 1'b0; run_cycles(3);
    check("stop_to_pause", int'(seq_state), 0);

    // Asynchronous reset while ticking every cycle
    run_sw = 1'b1; speed_sel = 2'd3; run_cycles(8);
    check("full_rate_tick", int'(cpu_tick), 1);
    #1 reset = 1'b1;
    #1;
    check("async_tick", int'(cpu_tick), 0);
    check("async_state", int'(seq_state), 0);
    check("async_led", int'(tick_led), 0);
    run_cycles(2);
    reset = 1'b0; speed_sel = 2'd2;
    n = 0;
    while (seq_state != 2'd1 && n < 10) begin step_cycle(); n++; end
    check("rerun_state", int'(seq_state), 1);
    n = 0;
    do begin step_cycle(); n++; end while (!cpu_tick && n < 20);
    check("first_tick_latency", n, lim_tab[2] + 1);

    // Randomized inputs against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0)   step_btn  = ~step_btn;
      if ($urandom_range(0, 79) == 0)   halt_req  = ~halt_req;
      if ($urandom_range(0, 149) == 0)  run_sw    = ~run_sw;
      if ($urandom_range(0, 119) == 0)  speed_sel = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 1499) == 0);
      step_cycle();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
